// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, instruction fields.
package cpu_pkg;

   // Instruction field positions
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 28;
   localparam int unsigned RD_MSB  = 27;
   localparam int unsigned RD_LSB  = 24;
   localparam int unsigned RA_MSB  = 23;
   localparam int unsigned RA_LSB  = 20;
   localparam int unsigned RB_MSB  = 19;
   localparam int unsigned RB_LSB  = 16;
   localparam int unsigned IMM_MSB = 15;
   localparam int unsigned IMM_LSB = 0;
   localparam int unsigned IMM_W   = 16;

   // Register file geometry
   localparam int unsigned NREGS  = 16;
   localparam int unsigned REG_AW = 4;

   // Opcodes
   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_AND  = 4'b0110;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_BNE  = 4'b1001;
   localparam logic [3:0] OP_LW   = 4'b1010;
   localparam logic [3:0] OP_SW   = 4'b1011;
   localparam logic [3:0] OP_ADDI = 4'b1100;
   localparam logic [3:0] OP_LUI  = 4'b1101;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_STOP
   } state_t;

   // True for opcodes whose result lands in Rd
   function automatic logic writes_rd(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
             (op == OP_ADDI) || (op == OP_LUI) || (op == OP_LW);
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 16-entry register file: two async read ports, one sync write port, R0 hardwired to zero.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] i_ra_addr,
   output logic [XLEN-1:0]   o_ra_data,
   input  logic [REG_AW-1:0] i_rb_addr,
   output logic [XLEN-1:0]   o_rb_data,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_wd_addr,
   input  logic [XLEN-1:0]   i_wd_data
);

   logic [XLEN-1:0] r_regs [NREGS];

   // Register storage; writes to R0 are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         r_regs <= '{default: '0};
      end else if (i_we && (i_wd_addr != '0)) begin
         r_regs[i_wd_addr] <= i_wd_data;
      end
   end

   assign o_ra_data = (i_ra_addr == '0) ? '0 : r_regs[i_ra_addr];
   assign o_rb_data = (i_rb_addr == '0) ? '0 : r_regs[i_rb_addr];

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle core: FETCH -> EXEC -> (MEM) -> WB, with a terminal STOP state.
module cpu_mc
   import cpu_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [XLEN-1:0] pc,
   output logic            retire,
   output logic            halted,
   output logic            illegal
);

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_next_pc;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_result;
   logic            r_imem_req;
   logic            r_dmem_req;
   logic            r_dmem_we;
   logic [XLEN-1:0] r_dmem_addr;
   logic [XLEN-1:0] r_dmem_wdata;
   logic            r_retire;
   logic            r_halted;
   logic            r_illegal;

   logic [3:0]       w_op;
   logic [IMM_W-1:0] w_imm;
   logic [XLEN-1:0]  w_sext;
   logic [XLEN-1:0]  w_ra_data;
   logic [XLEN-1:0]  w_rb_data;
   logic [XLEN-1:0]  w_alu;
   logic [XLEN-1:0]  w_pc_inc;
   logic [XLEN-1:0]  w_br_tgt;
   logic [XLEN-1:0]  w_pc_sel;
   logic             w_taken;
   logic             w_rf_we;

   assign w_op     = r_instr[OPC_MSB:OPC_LSB];
   assign w_imm    = r_instr[IMM_MSB:IMM_LSB];
   assign w_sext   = {{(XLEN-IMM_W){w_imm[IMM_W-1]}}, w_imm};
   assign w_pc_inc = r_pc + XLEN'(4);
   assign w_br_tgt = w_pc_inc + (w_sext << 2);
   assign w_taken  = ((w_op == OP_BEQ) && (w_ra_data == w_rb_data)) ||
                     ((w_op == OP_BNE) && (w_ra_data != w_rb_data));
   assign w_pc_sel = w_taken ? w_br_tgt : w_pc_inc;
   assign w_rf_we  = (r_state == ST_WB) && writes_rd(w_op);

   cpu_regfile #(.XLEN(XLEN)) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_ra_addr (r_instr[RA_MSB:RA_LSB]),
      .o_ra_data (w_ra_data),
      .i_rb_addr (r_instr[RB_MSB:RB_LSB]),
      .o_rb_data (w_rb_data),
      .i_we      (w_rf_we),
      .i_wd_addr (r_instr[RD_MSB:RD_LSB]),
      .i_wd_data (r_result)
   );

   // ALU result or effective address for the latched instruction
   always_comb begin
      w_alu = '0;
      unique case (w_op)
         OP_ADD:        w_alu = w_ra_data + w_rb_data;
         OP_SUB:        w_alu = w_ra_data - w_rb_data;
         OP_AND:        w_alu = w_ra_data & w_rb_data;
         OP_OR:         w_alu = w_ra_data | w_rb_data;
         OP_ADDI,
         OP_LW,
         OP_SW:         w_alu = w_ra_data + w_sext;
         OP_LUI:        w_alu = XLEN'({w_imm, 16'h0000});
         default:       w_alu = '0;
      endcase
   end

   // Control FSM with registered bus and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_FETCH;
         r_pc         <= RESET_PC;
         r_next_pc    <= RESET_PC;
         r_instr      <= '0;
         r_result     <= '0;
         r_imem_req   <= 1'b0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_retire     <= 1'b0;
         r_halted     <= 1'b0;
         r_illegal    <= 1'b0;
      end else begin
         r_retire <= 1'b0;
         unique case (r_state)
            ST_FETCH: begin
               // First cycle out of reset raises the request; ack only counts once it is up
               if (!r_imem_req) begin
                  r_imem_req <= 1'b1;
               end else if (imem_ack) begin
                  r_imem_req <= 1'b0;
                  r_instr    <= imem_rdata;
                  r_state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_result  <= w_alu;
               r_next_pc <= {w_pc_sel[XLEN-1:2], 2'b00};
               unique case (w_op)
                  OP_LW, OP_SW: begin
                     r_dmem_req   <= 1'b1;
                     r_dmem_we    <= (w_op == OP_SW);
                     r_dmem_addr  <= {w_alu[XLEN-1:2], 2'b00};
                     r_dmem_wdata <= w_rb_data;
                     r_state      <= ST_MEM;
                  end
                  OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
                  OP_BEQ, OP_BNE, OP_ADDI, OP_LUI: begin
                     r_retire <= 1'b1;
                     r_state  <= ST_WB;
                  end
                  OP_HALT: begin
                     r_halted <= 1'b1;
                     r_state  <= ST_STOP;
                  end
                  default: begin
                     r_halted  <= 1'b1;
                     r_illegal <= 1'b1;
                     r_state   <= ST_STOP;
                  end
               endcase
            end
            ST_MEM: begin
               if (dmem_ack) begin
                  r_dmem_req <= 1'b0;
                  r_dmem_we  <= 1'b0;
                  if (!r_dmem_we) begin
                     r_result <= dmem_rdata;
                  end
                  r_retire <= 1'b1;
                  r_state  <= ST_WB;
               end
            end
            ST_WB: begin
               r_pc       <= r_next_pc;
               r_imem_req <= 1'b1;
               r_state    <= ST_FETCH;
            end
            ST_STOP: begin
               r_state <= ST_STOP;
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

   assign imem_req   = r_imem_req;
   assign imem_addr  = {r_pc[XLEN-1:2], 2'b00};
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_wdata = r_dmem_wdata;
   assign pc         = r_pc;
   assign retire     = r_retire;
   assign halted     = r_halted;
   assign illegal    = r_illegal;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed self-checking bench for cpu_mc with a simple wait-state memory model.
module tb_cpu_mc;

   localparam logic [3:0] NOP = 4'h0, ADD = 4'h4, SUB = 4'h5, BEQ = 4'h8, BNE = 4'h9;
   localparam logic [3:0] LW = 4'hA, SW = 4'hB, ADDI = 4'hC, LUI = 4'hD, HALT = 4'hF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
   logic        retire, halted, illegal;

   int          checks = 0;
   int          errors = 0;
   int          i_delay = 0;
   int          d_delay = 0;
   int          i_wait = 0;
   int          d_wait = 0;
   int          cyc = 0;
   int          overlap = 0;
   int          dreq_cyc = 0;

   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   logic [31:0] fetch_q [$];
   int          ret_q [$];
   logic [31:0] acc_addr_q [$];
   logic [31:0] acc_data_q [$];
   logic        acc_we_q [$];

   cpu_mc #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .pc         (pc),
      .retire     (retire),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // Memory responders: ack after a programmable number of wait cycles
   always_comb begin
      imem_ack   = imem_req && (i_wait == i_delay);
      imem_rdata = imem[imem_addr[7:2]];
      dmem_ack   = dmem_req && (d_wait == d_delay);
      dmem_rdata = dmem[dmem_addr[7:2]];
   end

   // Wait counters, data memory writes and activity log
   always @(posedge clk) begin
      i_wait <= (!imem_req || imem_ack) ? 0 : i_wait + 1;
      d_wait <= (!dmem_req || dmem_ack) ? 0 : d_wait + 1;
      cyc    <= cyc + 1;
      if (imem_req && dmem_req) overlap <= overlap + 1;
      if (dmem_req) dreq_cyc <= dreq_cyc + 1;
      if (imem_req && imem_ack) fetch_q.push_back(imem_addr);
      if (retire) ret_q.push_back(cyc);
      if (dmem_req && dmem_ack) begin
         acc_addr_q.push_back(dmem_addr);
         acc_data_q.push_back(dmem_wdata);
         acc_we_q.push_back(dmem_we);
         if (dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
      end
   end

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [15:0] imm);
      return {op, rd, ra, rb, imm};
   endfunction

   task automatic fill_imem(input logic [31:0] w);
      for (int k = 0; k < 64; k++) imem[k] = w;
   endtask

   // Hold reset, clear logs, release; returns at the first negedge after release
   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      fetch_q.delete();
      ret_q.delete();
      acc_addr_q.delete();
      acc_data_q.delete();
      acc_we_q.delete();
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_to_halt(input int max_cyc);
      int n = 0;
      while (!halted && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, n);
      end
   endtask

   task automatic test_reset();
      fill_imem(enc(HALT, 0, 0, 0, 0));
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b required 0", imem_req); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", pc); end
      checks++; if ({retire, halted, illegal} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b required 000", {retire, halted, illegal}); end
      checks++; if ({dmem_req, dmem_we} !== 2'b00) begin errors++; $display("FAIL rst_dmem_ctl: got %b required 00", {dmem_req, dmem_we}); end
      checks++; if ({dmem_addr, dmem_wdata} !== 64'h0) begin errors++; $display("FAIL rst_dmem_bus: got %h required 0", {dmem_addr, dmem_wdata}); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL post_rst_fetch: got req=%b addr=%h required 1/0", imem_req, imem_addr); end
   endtask

   task automatic test_alu();
      fill_imem(enc(HALT, 0, 0, 0, 0));
      i_delay = 0; d_delay = 0;
      imem[0]  = enc(ADDI, 1, 0, 0, 16'd1);
      imem[1]  = enc(ADDI, 2, 0, 0, 16'd2);
      imem[2]  = enc(ADD,  3, 1, 2, 16'd0);
      imem[3]  = enc(SW,   0, 0, 3, 16'h0044);
      imem[4]  = enc(SUB,  4, 1, 2, 16'd0);
      imem[5]  = enc(SW,   0, 0, 4, 16'h0048);
      imem[6]  = enc(LUI,  3, 0, 0, 16'hFFFF);
      imem[7]  = enc(SW,   0, 0, 3, 16'h004C);
      imem[8]  = enc(ADDI, 0, 1, 0, 16'd5);
      imem[9]  = enc(SW,   0, 0, 0, 16'h0050);
      do_reset();
      run_to_halt(200);
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL alu_illegal: got %b required 0", illegal); end
      checks++; if (fetch_q.size() < 3 || fetch_q[0] !== 32'h0 || fetch_q[1] !== 32'h4 || fetch_q[2] !== 32'h8) begin
         errors++; $display("FAIL alu_fetch_addr: got %0d entries, first %h %h %h required 0 4 8", fetch_q.size(), fetch_q[0], fetch_q[1], fetch_q[2]); end
      checks++; if (ret_q.size() !== 10) begin errors++; $display("FAIL alu_retire_count: got %0d required 10", ret_q.size()); end
      checks++; if (ret_q[1] - ret_q[0] !== 3 || ret_q[2] - ret_q[1] !== 3) begin
         errors++; $display("FAIL alu_retire_gap: got %0d %0d required 3 3", ret_q[1] - ret_q[0], ret_q[2] - ret_q[1]); end
      checks++; if (ret_q[3] - ret_q[2] !== 4) begin errors++; $display("FAIL sw_retire_gap: got %0d required 4", ret_q[3] - ret_q[2]); end
      checks++; if (acc_data_q.size() !== 4) begin errors++; $display("FAIL alu_store_count: got %0d required 4", acc_data_q.size()); end
      checks++; if (acc_data_q[0] !== 32'd3) begin errors++; $display("FAIL add_r3: got %h required 3", acc_data_q[0]); end
      checks++; if (acc_data_q[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_r4: got %h required ffffffff", acc_data_q[1]); end
      checks++; if (acc_data_q[2] !== 32'hFFFF_0000) begin errors++; $display("FAIL lui_r3: got %h required ffff0000", acc_data_q[2]); end
      checks++; if (acc_data_q[3] !== 32'h0) begin errors++; $display("FAIL r0_write: got %h required 0", acc_data_q[3]); end
      checks++; if (acc_addr_q[1] !== 32'h48) begin errors++; $display("FAIL alu_store_addr: got %h required 48", acc_addr_q[1]); end
   endtask

   task automatic test_branch();
      fill_imem(enc(HALT, 0, 0, 0, 0));
      i_delay = 0; d_delay = 0;
      imem[0] = enc(ADDI, 1, 0, 0, 16'd1);
      imem[1] = enc(ADDI, 2, 0, 0, 16'd2);
      imem[2] = enc(NOP, 0, 0, 0, 0);
      imem[3] = enc(NOP, 0, 0, 0, 0);
      imem[4] = enc(BEQ, 0, 1, 1, 16'd2);
      imem[7] = enc(NOP, 0, 0, 0, 0);
      imem[8] = enc(BNE, 0, 1, 2, 16'hFFFF);
      do_reset();
      repeat (40) @(negedge clk);
      checks++; if (fetch_q[5] !== 32'h1C) begin errors++; $display("FAIL beq_taken: got %h required 1c", fetch_q[5]); end
      checks++; if (fetch_q[7] !== 32'h20 || fetch_q[8] !== 32'h20) begin errors++; $display("FAIL bne_back: got %h %h required 20 20", fetch_q[7], fetch_q[8]); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL bne_loop_halted: got %b required 0", halted); end
      // Not-taken BEQ falls through to pc+4
      imem[4] = enc(BEQ, 0, 1, 2, 16'd2);
      imem[5] = enc(HALT, 0, 0, 0, 0);
      do_reset();
      run_to_halt(100);
      checks++; if (fetch_q[5] !== 32'h14) begin errors++; $display("FAIL beq_not_taken: got %h required 14", fetch_q[5]); end
      checks++; if (pc !== 32'h14 || illegal !== 1'b0) begin errors++; $display("FAIL halt_pc: got pc=%h illegal=%b required 14/0", pc, illegal); end
   endtask

   task automatic test_imem_wait();
      fill_imem(enc(HALT, 0, 0, 0, 0));
      imem[0] = enc(NOP, 0, 0, 0, 0);
      i_delay = 3; d_delay = 0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h0 || retire !== 1'b0) begin
            errors++; $display("FAIL imem_wait_hold%0d: got req=%b addr=%h retire=%b required 1/0/0", k, imem_req, imem_addr, retire);
         end
         @(negedge clk);
      end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL imem_wait_release: got %b required 0", imem_req); end
      run_to_halt(100);
      checks++; if (fetch_q.size() !== 2 || fetch_q[1] !== 32'h4) begin errors++; $display("FAIL imem_wait_seq: got %0d entries second %h required 2/4", fetch_q.size(), fetch_q[1]); end
      i_delay = 0;
   endtask

   task automatic test_mem();
      int base_dreq;
      fill_imem(enc(HALT, 0, 0, 0, 0));
      i_delay = 0; d_delay = 2;
      imem[0] = enc(ADDI, 2, 0, 0, 16'd2);
      imem[1] = enc(SW, 0, 0, 2, 16'h0040);
      imem[2] = enc(LW, 5, 0, 0, 16'h0040);
      imem[3] = enc(SW, 0, 0, 5, 16'h0054);
      imem[4] = enc(SW, 0, 0, 2, 16'h0047);
      do_reset();
      base_dreq = dreq_cyc;
      run_to_halt(200);
      checks++; if (acc_we_q.size() !== 4) begin errors++; $display("FAIL mem_access_count: got %0d required 4", acc_we_q.size()); end
      checks++; if (acc_addr_q[0] !== 32'h40 || acc_we_q[0] !== 1'b1 || acc_data_q[0] !== 32'd2) begin
         errors++; $display("FAIL sw_access: got addr=%h we=%b data=%h required 40/1/2", acc_addr_q[0], acc_we_q[0], acc_data_q[0]); end
      checks++; if (acc_addr_q[1] !== 32'h40 || acc_we_q[1] !== 1'b0) begin
         errors++; $display("FAIL lw_access: got addr=%h we=%b required 40/0", acc_addr_q[1], acc_we_q[1]); end
      checks++; if (acc_data_q[2] !== 32'd2) begin errors++; $display("FAIL lw_r5: got %h required 2", acc_data_q[2]); end
      checks++; if (acc_addr_q[3] !== 32'h44) begin errors++; $display("FAIL dmem_align: got %h required 44", acc_addr_q[3]); end
      checks++; if (dreq_cyc - base_dreq !== 12) begin errors++; $display("FAIL dmem_wait_cycles: got %0d required 12", dreq_cyc - base_dreq); end
      checks++; if (overlap !== 0) begin errors++; $display("FAIL req_overlap: got %0d required 0", overlap); end
      d_delay = 0;
   endtask

   task automatic test_illegal();
      int reqs = 0;
      fill_imem(enc(HALT, 0, 0, 0, 0));
      imem[0] = enc(ADDI, 1, 0, 0, 16'd1);
      imem[1] = enc(4'b0011, 1, 1, 1, 16'h1234);
      do_reset();
      run_to_halt(100);
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b required 1", illegal); end
      repeat (10) begin
         @(negedge clk);
         if (imem_req || dmem_req) reqs++;
      end
      checks++; if (reqs !== 0) begin errors++; $display("FAIL stop_requests: got %0d required 0", reqs); end
      checks++; if (pc !== 32'h4 || ret_q.size() !== 1) begin errors++; $display("FAIL stop_frozen: got pc=%h retires=%0d required 4/1", pc, ret_q.size()); end
   endtask

   task automatic test_reset_mid_access();
      int n = 0;
      fill_imem(enc(NOP, 0, 0, 0, 0));
      i_delay = 0; d_delay = 0;
      do_reset();
      while (!(imem_req && pc == 32'h8) && n < 50) begin @(negedge clk); n++; end
      checks++; if (imem_req !== 1'b1 || imem_ack !== 1'b1) begin errors++; $display("FAIL mid_fetch_setup: got req=%b ack=%b required 1/1", imem_req, imem_ack); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || retire !== 1'b0) begin
         errors++; $display("FAIL rst_mid_fetch: got req=%b pc=%h retire=%b required 0/0/0", imem_req, pc, retire); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL refetch: got req=%b addr=%h required 1/0", imem_req, imem_addr); end
      // Reset while a store is waiting for its ack
      imem[0] = enc(SW, 0, 0, 0, 16'h0060);
      d_delay = 5;
      do_reset();
      n = 0;
      while (!dmem_req && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({dmem_req, dmem_we} !== 2'b00 || dmem_addr !== 32'h0 || acc_we_q.size() !== 0) begin
         errors++; $display("FAIL rst_mid_mem: got req=%b we=%b addr=%h acc=%0d required 0/0/0/0", dmem_req, dmem_we, dmem_addr, acc_we_q.size()); end
      rst = 1'b0;
      d_delay = 0;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_imem_wait();
      test_mem();
      test_illegal();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/cpu_mc.md
CPU_MC -- requirements
Module: cpu_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath/register/address width; values below 32 are illegal.
REQ-002 Parameter RESET_PC, default 0, PC value loaded by reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_req  output  1  instruction fetch request; imem_addr  output  XLEN  fetch byte address.
REQ-006 imem_ack  input  1  fetch complete this cycle; imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-007 dmem_req  output  1  data request; dmem_we  output  1  1 = store; dmem_addr  output  XLEN  byte address; dmem_wdata  output  XLEN  store data.
REQ-008 dmem_ack  input  1  data access complete; dmem_rdata  input  XLEN  load data, valid with dmem_ack.
REQ-009 pc  output  XLEN  current PC; retire  output  1  one-cycle pulse per completed instruction.
REQ-010 halted  output  1  core stopped; illegal  output  1  stop caused by an undefined opcode.

Function
REQ-011 Instruction fields: [31:28] opcode, [27:24] Rd, [23:20] Ra, [19:16] Rb, [15:0] imm; sext = imm sign-extended to XLEN.
REQ-012 Opcodes: 0000 NOP; 0100 ADD Rd=Ra+Rb; 0101 SUB Rd=Ra-Rb; 0110 AND; 0111 OR; 1000 BEQ; 1001 BNE; 1010 LW Rd=mem[Ra+sext]; 1011 SW mem[Ra+sext]=Rb; 1100 ADDI Rd=Ra+sext; 1101 LUI Rd=imm<<16, lower bits 0; 1111 HALT; all others illegal.
REQ-013 All arithmetic is modulo 2^XLEN; no flags and no overflow detection.
REQ-014 16 registers of XLEN bits; R0 reads as 0; writes to R0 are discarded.
REQ-015 FSM states: FETCH, EXEC, MEM, WB, STOP.
REQ-016 FETCH: imem_req=1, imem_addr=pc held stable; on imem_ack latch imem_rdata and go to EXEC; imem_ack in the same cycle as the first req cycle is legal.
REQ-017 EXEC: read Ra/Rb, compute ALU result or effective address; LW/SW go to MEM; HALT or illegal goes to STOP; all other opcodes go to WB.
REQ-018 MEM: dmem_req=1 with addr/we/wdata held stable until dmem_ack; on ack latch dmem_rdata (LW) and go to WB.
REQ-019 WB: write Rd for ALU/LUI/LW; update pc; pulse retire; go to FETCH.
REQ-020 Next pc = pc+4; for BEQ taken (Ra==Rb) or BNE taken (Ra!=Rb), next pc = pc+4+(sext<<2); wraps modulo 2^XLEN.
REQ-021 With zero-wait memory, ALU/branch/NOP instructions take 3 cycles and LW/SW take 4 cycles, from FETCH entry to the next FETCH entry.
REQ-022 dmem_addr[1:0] is forced to 00; imem_addr is always word aligned.
REQ-023 STOP: halted=1; no requests issued; pc frozen; exited only by rst; illegal=1 only when STOP was entered via an undefined opcode.
REQ-024 imem_ack and dmem_ack are ignored outside FETCH and MEM respectively.
REQ-025 imem_req and dmem_req are never asserted in the same cycle.

Reset
REQ-026 rst=1 forces: state FETCH, pc=RESET_PC, all registers 0, retire/halted/illegal/dmem_req/dmem_we=0, dmem_addr/dmem_wdata=0.
REQ-027 imem_req is 1 in the first cycle after rst deasserts.
REQ-028 rst asserted mid-FETCH or mid-MEM drops the request in the next cycle; a coincident ack is discarded and no register or PC update occurs.

Structure
REQ-029 Shared package cpu_pkg holds the opcode constants, the FSM state enum and the instruction field positions.
REQ-030 Sub-module cpu_regfile: 16xXLEN registers, two asynchronous read ports, one synchronous write port, R0 hardwired to 0.

Verification
REQ-031 Zero-wait memory; ADDI R1,R0,1; ADDI R2,R0,2; ADD R3,R1,R2 -> R3=3; retire every 3 cycles; imem_addr 0,4,8.
REQ-032 SUB R4,R1,R2 -> R4=0xFFFFFFFF; LUI R3,0xFFFF -> R3=0xFFFF0000; ADDI R0,R1,5 -> R0 still reads 0.
REQ-033 BEQ R1,R1,imm=2 at pc 0x10 -> next imem_addr 0x1C; BEQ R1,R2 (1!=2) -> 0x14; BNE R1,R2,imm=0xFFFF at 0x20 -> 0x20.
REQ-034 imem_ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles; no retire during the wait.
REQ-035 SW R2 to address R0+0x40, then LW R5 from R0+0x40, dmem_ack delayed 2 cycles -> dmem_addr 0x40, dmem_we 1 then 0, R5=2.
REQ-036 Opcode 0011 -> halted=1, illegal=1, no further requests; rst during FETCH with a coincident ack -> imem_req=0 next cycle, pc=RESET_PC.
